// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
// Holds the controller state encoding and the configuration legality helper.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  // A pattern must be at least two bits long and fit the history register
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 32'd2) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear and an increment
// on the same edge yield a count of one.
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] base_s;
  logic [CNT_W-1:0] count_nxt_s;

  // Next count: apply clear first, then a saturating increment
  always_comb begin
    base_s      = clr ? {CNT_W{1'b0}} : count_r;
    count_nxt_s = base_s;
    if (inc && (base_s != {CNT_W{1'b1}})) begin
      count_nxt_s = base_s + CNT_W'(1);
    end else begin
      count_nxt_s = base_s;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/prog_seq_detector.sv
// Programmable serial pattern detector: matches the last cfg_len valid bits
// against a loaded pattern, with overlapping or non-overlapping detection.
module prog_seq_detector
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         clr_count,
  output logic                         detected,
  output logic [CNT_W-1:0]             match_count,
  output logic                         armed,
  output logic                         cfg_err
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [MAX_LEN-1:0] pattern_r;
  logic [LEN_W-1:0]   len_r;
  logic               overlap_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic               detected_r;
  logic               cfg_err_r;

  logic               load_ok_s;
  logic               take_bit_s;
  logic [MAX_LEN-1:0] hist_upd_s;
  logic [LEN_W-1:0]   fill_upd_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               match_s;

  // Controller next state: only a configuration load moves between states
  always_comb begin
    load_ok_s   = len_legal(32'(cfg_len), MAX_LEN);
    state_nxt_s = state_r;
    if (cfg_load) begin
      if (load_ok_s) begin
        state_nxt_s = ST_ARMED;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Match evaluation against the history as it will look after this bit
  always_comb begin
    take_bit_s = (state_r == ST_ARMED) && bit_valid && !cfg_load;
    hist_upd_s = {hist_r[MAX_LEN-2:0], bit_in};
    fill_upd_s = (fill_r == FILL_MAX) ? fill_r : (fill_r + LEN_W'(1));
    mask_s     = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_r);
    end
    match_s = take_bit_s && (fill_upd_s >= len_r) &&
              (((hist_upd_s ^ pattern_r) & mask_s) == {MAX_LEN{1'b0}});
  end

  // Configuration latch, bit history and fill tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      pattern_r <= {MAX_LEN{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      overlap_r <= 1'b0;
      hist_r    <= {MAX_LEN{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
      cfg_err_r <= 1'b0;
    end else if (cfg_load) begin
      cfg_err_r <= !load_ok_s;
      if (load_ok_s) begin
        pattern_r <= cfg_pattern;
        len_r     <= cfg_len;
        overlap_r <= cfg_overlap;
        hist_r    <= {MAX_LEN{1'b0}};
        fill_r    <= {LEN_W{1'b0}};
      end
    end else begin
      cfg_err_r <= 1'b0;
      if (take_bit_s) begin
        hist_r <= hist_upd_s;
        // Non-overlapping mode demands a fresh run of len bits after a hit
        fill_r <= (match_s && !overlap_r) ? {LEN_W{1'b0}} : fill_upd_s;
      end
    end
  end

  // Registered match pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      detected_r <= 1'b0;
    end else begin
      detected_r <= match_s;
    end
  end

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_count),
    .inc   (match_s),
    .count (match_count)
  );

  assign detected = detected_r;
  assign armed    = (state_r == ST_ARMED);
  assign cfg_err  = cfg_err_r;

endmodule

// File: tb/tb_prog_seq_detector.sv
// Directed self-checking bench for prog_seq_detector (MAX_LEN=8, CNT_W=2).
module tb_prog_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk;
  logic               rst;
  logic               bit_in;
  logic               bit_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clr_count;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               armed;
  logic               cfg_err;

  int compared   = 0;
  int mismatched = 0;

  prog_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .clr_count   (clr_count),
    .detected    (detected),
    .match_count (match_count),
    .armed       (armed),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] pat, input int len, input logic ovl);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input string tag, input logic b, input logic exp_det);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    check(tag, 32'(detected), 32'(exp_det));
  endtask

  task automatic clear_count();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
  endtask

  initial begin
    rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = '0; cfg_overlap = 1'b0; clr_count = 1'b0;
    tick(); tick();
    check("rst_detected", 32'(detected), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b1;
    tick();

    // 1011 overlapping on 1,0,1,1,0,1,1
    load(8'b0000_1011, 4, 1'b1);
    check("ld1011_armed", 32'(armed), 32'd1);
    check("ld1011_err", 32'(cfg_err), 32'd0);
    send("ov1011_b1", 1'b1, 1'b0);
    send("ov1011_b2", 1'b0, 1'b0);
    send("ov1011_b3", 1'b1, 1'b0);
    send("ov1011_b4", 1'b1, 1'b1);
    send("ov1011_b5", 1'b0, 1'b0);
    send("ov1011_b6", 1'b1, 1'b0);
    send("ov1011_b7", 1'b1, 1'b1);
    check("ov1011_count", 32'(match_count), 32'd2);
    tick();
    check("ov1011_pulse_end", 32'(detected), 32'd0);

    // 101 overlapping on 1,0,1,0,1
    clear_count();
    check("clr_count", 32'(match_count), 32'd0);
    load(8'b0000_0101, 3, 1'b1);
    send("ov101_b1", 1'b1, 1'b0);
    send("ov101_b2", 1'b0, 1'b0);
    send("ov101_b3", 1'b1, 1'b1);
    send("ov101_b4", 1'b0, 1'b0);
    send("ov101_b5", 1'b1, 1'b1);
    check("ov101_count", 32'(match_count), 32'd2);

    // 101 non-overlapping on 1,0,1,0,1
    clear_count();
    load(8'b0000_0101, 3, 1'b0);
    send("no101_b1", 1'b1, 1'b0);
    send("no101_b2", 1'b0, 1'b0);
    send("no101_b3", 1'b1, 1'b1);
    send("no101_b4", 1'b0, 1'b0);
    send("no101_b5", 1'b1, 1'b0);
    check("no101_count", 32'(match_count), 32'd1);

    // 1011 with three idle cycles after every bit
    clear_count();
    load(8'b0000_1011, 4, 1'b1);
    send("gap_b1", 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin tick(); check("gap_idle1", 32'(detected), 32'd0); end
    send("gap_b2", 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin tick(); check("gap_idle2", 32'(detected), 32'd0); end
    send("gap_b3", 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin tick(); check("gap_idle3", 32'(detected), 32'd0); end
    send("gap_b4", 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin tick(); check("gap_idle4", 32'(detected), 32'd0); end
    check("gap_count", 32'(match_count), 32'd1);

    // 11 overlapping on six ones: counter saturates at 3
    clear_count();
    load(8'b0000_0011, 2, 1'b1);
    send("sat_b1", 1'b1, 1'b0);
    check("sat_cnt1", 32'(match_count), 32'd0);
    send("sat_b2", 1'b1, 1'b1);
    check("sat_cnt2", 32'(match_count), 32'd1);
    send("sat_b3", 1'b1, 1'b1);
    check("sat_cnt3", 32'(match_count), 32'd2);
    send("sat_b4", 1'b1, 1'b1);
    check("sat_cnt4", 32'(match_count), 32'd3);
    send("sat_b5", 1'b1, 1'b1);
    check("sat_cnt5", 32'(match_count), 32'd3);
    send("sat_b6", 1'b1, 1'b1);
    check("sat_cnt6", 32'(match_count), 32'd3);
    clr_count = 1'b1;
    send("clr_match_det", 1'b1, 1'b1);
    clr_count = 1'b0;
    check("clr_match_count", 32'(match_count), 32'd1);

    // Illegal length 0
    load(8'b0000_1011, 0, 1'b1);
    check("len0_err", 32'(cfg_err), 32'd1);
    check("len0_armed", 32'(armed), 32'd0);
    check("len0_count", 32'(match_count), 32'd1);
    send("len0_b1", 1'b1, 1'b0);
    check("len0_err_pulse", 32'(cfg_err), 32'd0);
    send("len0_b2", 1'b0, 1'b0);
    send("len0_b3", 1'b1, 1'b0);
    send("len0_b4", 1'b1, 1'b0);

    // Illegal length MAX_LEN+1, loaded while armed
    load(8'b0000_1011, 4, 1'b1);
    check("relegal_armed", 32'(armed), 32'd1);
    load(8'b0000_1011, MAX_LEN + 1, 1'b1);
    check("len9_err", 32'(cfg_err), 32'd1);
    check("len9_armed", 32'(armed), 32'd0);
    send("len9_b1", 1'b1, 1'b0);
    check("len9_err_pulse", 32'(cfg_err), 32'd0);
    send("len9_b2", 1'b0, 1'b0);
    send("len9_b3", 1'b1, 1'b0);
    send("len9_b4", 1'b1, 1'b0);
    check("illegal_count", 32'(match_count), 32'd1);

    // Reset in the middle of a partial match
    load(8'b0000_1011, 4, 1'b1);
    send("mid_b1", 1'b1, 1'b0);
    send("mid_b2", 1'b0, 1'b0);
    send("mid_b3", 1'b1, 1'b0);
    rst = 1'b0;
    cfg_load = 1'b1;
    clr_count = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick();
    cfg_load = 1'b0; clr_count = 1'b0; bit_valid = 1'b0;
    check("mid_rst_detected", 32'(detected), 32'd0);
    check("mid_rst_count", 32'(match_count), 32'd0);
    check("mid_rst_armed", 32'(armed), 32'd0);
    check("mid_rst_err", 32'(cfg_err), 32'd0);
    rst = 1'b1;
    send("post_rst_b4", 1'b1, 1'b0);
    check("post_rst_armed", 32'(armed), 32'd0);
    check("post_rst_count", 32'(match_count), 32'd0);
    load(8'b0000_1011, 4, 1'b1);
    check("reload_armed", 32'(armed), 32'd1);
    send("reload_b1", 1'b1, 1'b0);
    send("reload_b2", 1'b0, 1'b0);
    send("reload_b3", 1'b1, 1'b0);
    send("reload_b4", 1'b1, 1'b1);
    check("reload_count", 32'(match_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prog_seq_detector.md
PROG_SEQ_DETECTOR -- requirements
Module: prog_seq_detector

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning maximum pattern length in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the match counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (rst=0 resets on next rising clk edge).
REQ-005 SHALL have port bit_in  input  1  serial data bit, sampled only when bit_valid=1.
REQ-006 SHALL have port bit_valid  input  1  qualifies bit_in for the current cycle.
REQ-007 SHALL have port cfg_load  input  1  single-cycle strobe; loads cfg_pattern, cfg_len and cfg_overlap.
REQ-008 SHALL have port cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
REQ-009 SHALL have port cfg_len  input  $clog2(MAX_LEN+1)  active pattern length.
REQ-010 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL have port clr_count  input  1  synchronous clear of match_count.
REQ-012 SHALL have port detected  output  1  one-cycle match pulse, registered.
REQ-013 SHALL have port match_count  output  CNT_W  saturating count of matches.
REQ-014 SHALL have port armed  output  1  high when a legal configuration is loaded.
REQ-015 SHALL have port cfg_err  output  1  one-cycle pulse on an illegal load.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no legal configuration) and ARMED; armed=1 exactly in ARMED.
REQ-017 SHALL, on cfg_load with 2<=cfg_len<=MAX_LEN, latch pattern/len/overlap, clear history and fill count, and enter ARMED on the next edge.
REQ-018 SHALL, on cfg_load with cfg_len<2 or cfg_len>MAX_LEN, enter IDLE, pulse cfg_err for one cycle, and leave match_count unchanged.
REQ-019 SHALL ignore bit_in in the cycle cfg_load=1 (load takes priority over data).
REQ-020 SHALL, in ARMED with bit_valid=1, shift bit_in into the LSB of a MAX_LEN-bit history register and increment a saturating fill count (saturates at MAX_LEN).
REQ-021 SHALL hold history and fill count unchanged when bit_valid=0; gaps in bit_valid SHALL NOT break a match.
REQ-022 SHALL declare a match when fill count >= len and the low len bits of the updated history equal cfg_pattern[len-1:0].
REQ-023 SHALL assert detected for exactly one cycle, in the cycle after the edge that sampled the completing bit.
REQ-024 SHALL, in overlap mode, keep history after a match, so suffixes count toward the next match.
REQ-025 SHALL, in non-overlap mode, reset fill count to 0 on a match, so the next match needs len fresh valid bits.
REQ-026 SHALL increment match_count on each match, saturating at 2^CNT_W-1 with no wrap.
REQ-027 SHALL, if clr_count and a match occur on the same edge, set match_count to 1 (clear then count).
REQ-028 SHALL never assert detected or count in IDLE.

Reset
REQ-029 SHALL, with rst=0 at a rising edge, set FSM=IDLE, history=0, fill=0, detected=0, match_count=0, armed=0, cfg_err=0, and latched config=0.
REQ-030 SHALL apply reset mid-stream with full priority over cfg_load, bit_valid and clr_count; a partial match SHALL be discarded.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, ARMED) and the MAX_LEN/CNT_W default constants in shared package seq_det_pkg.
REQ-032 SHALL implement the saturating counter with synchronous clear as sub-module seq_det_sat_cnt (params CNT_W).

Verification
REQ-033 SHALL test: load 1011 len4 overlap, stream 1,0,1,1,0,1,1 -> detected after bits 4 and 7, match_count=2.
REQ-034 SHALL test: load 101 len3, stream 1,0,1,0,1 -> overlap: detects after bits 3 and 5, count=2; non-overlap: only after bit 3, count=1.
REQ-035 SHALL test: pattern 1011 with bit_valid low for 3 cycles between every bit -> still exactly one detect, count=1.
REQ-036 SHALL test: CNT_W=2, pattern 11 len2 overlap, 6 ones -> 5 matches, count saturates at 3; clr_count with a match on the same edge -> count=1.
REQ-037 SHALL test: cfg_len=0 and cfg_len=MAX_LEN+1 -> cfg_err one-cycle pulse, armed=0, no detects on the 1011 stream.
REQ-038 SHALL test: rst=0 after bits 1,0,1 of 1011, then release and send 1 -> no detect; all outputs 0 after reset, armed=0 until reload.
